fetch_stage: RTL and testbench



---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 tb/tb_fetch_stage.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
//
// Handshake (valid/ready semantics for this bus):
//   - imem_req is a one-cycle pulse. It is accepted the cycle it is high.
//     There is no ready signal, and at most one request is outstanding.
//   - imem_valid is a one-cycle strobe qualifying imem_rdata. It arrives at
//     least one cycle after the request it answers.
//
// Signals:
//   imem_req   : request pulse          (fetch -> memory)
//   imem_addr  : request address        (fetch -> memory)
//   imem_valid : response strobe        (memory -> fetch)
//   imem_rdata : response instruction   (memory -> fetch)
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_valid, input imem_rdata);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_valid, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the multicycle RISC-V core.
// Holds the fetch PC and issues one request at a time. It absorbs a decode
// stall in a one-entry hold buffer and kills in-flight fetches on redirect.
// It writes the IF/ID register that feeds the decode controller.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   stall             : hold IF/ID (load-use hazard, !dhit, alu_busy)
//   redirect          : taken branch/jump resolved this cycle
//   redirect_pc       : redirect target
//   imem              : instruction-memory bus (master side)
//   instr_d, pc_d     : IF/ID instruction and PC
//   opcode/funct3/funct7 : slices of instr_d
//   ihit              : fetched instruction available this cycle
//   sendNop           : IF/ID holds a bubble
//   dbg_state         : FSM state (0=REQ, 1=WAIT, 2=HOLD)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  fetch_stage_if.master imem,
  output logic [31:0]  instr_d,
  output logic [31:0]  pc_d,
  output logic [6:0]   opcode,
  output logic [2:0]   funct3,
  output logic [6:0]   funct7,
  output logic         ihit,
  output logic         sendNop,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic        kill_q, kill_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic        valid_d_q, valid_d_d;

  // An instruction ready to enter IF/ID this cycle (fresh or from hold_buf).
  logic        new_valid;
  logic [31:0] new_instr;

  always_comb begin
    state_d       = state_q;
    pc_f_d        = pc_f_q;
    kill_d        = kill_q;
    hold_buf_d    = hold_buf_q;
    new_valid     = 1'b0;
    new_instr     = hold_buf_q;
    imem.imem_req = 1'b0;

    case (state_q)
      S_REQ: begin
        imem.imem_req = ~reset & ~redirect;
        if (redirect) begin
          pc_f_d = redirect_pc;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_f_d = redirect_pc;
          if (imem.imem_valid) begin
            // Response for the stale PC lands with the redirect: drop it.
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            // Response still in flight: remember to drop it when it arrives.
            kill_d  = 1'b1;
          end
        end else if (imem.imem_valid && kill_q) begin
          kill_d  = 1'b0;
          state_d = S_REQ;
        end else if (imem.imem_valid && !stall) begin
          new_valid = 1'b1;
          new_instr = imem.imem_rdata;
          pc_f_d    = pc_f_q + 32'd4;
          state_d   = S_REQ;
        end else if (imem.imem_valid) begin
          hold_buf_d = imem.imem_rdata;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          // hold_buf is simply abandoned; it is overwritten before reuse.
          pc_f_d  = redirect_pc;
          state_d = S_REQ;
        end else if (!stall) begin
          new_valid = 1'b1;
          new_instr = hold_buf_q;
          pc_f_d    = pc_f_q + 32'd4;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // IF/ID: redirect flush beats stall, stall beats a new load.
    instr_d_d = instr_d_q;
    pc_d_d    = pc_d_q;
    valid_d_d = valid_d_q;
    if (redirect) begin
      instr_d_d = NOP;
      valid_d_d = 1'b0;
    end else if (stall) begin
      instr_d_d = instr_d_q;
    end else if (new_valid) begin
      instr_d_d = new_instr;
      pc_d_d    = pc_f_q;
      valid_d_d = 1'b1;
    end else begin
      instr_d_d = NOP;
      valid_d_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_f_q     <= RESET_PC;
      kill_q     <= 1'b0;
      hold_buf_q <= 32'd0;
      instr_d_q  <= NOP;
      pc_d_q     <= 32'd0;
      valid_d_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_f_q     <= pc_f_d;
      kill_q     <= kill_d;
      hold_buf_q <= hold_buf_d;
      instr_d_q  <= instr_d_d;
      pc_d_q     <= pc_d_d;
      valid_d_q  <= valid_d_d;
    end
  end

  assign imem.imem_addr = pc_f_q;
  assign instr_d        = instr_d_q;
  assign pc_d           = pc_d_q;
  assign opcode         = instr_d_q[6:0];
  assign funct3         = instr_d_q[14:12];
  assign funct7         = instr_d_q[31:25];
  assign sendNop        = ~valid_d_q;
  assign dbg_state      = state_q;
  assign ihit           = ~redirect &
                          (((state_q == S_WAIT) & imem.imem_valid & ~kill_q) |
                           (state_q == S_HOLD));

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_1000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d, pc_d;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        ihit, sendNop;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(bus),
    .instr_d(instr_d), .pc_d(pc_d), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .ihit(ihit), .sendNop(sendNop), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Contents of instruction memory: an arbitrary fixed scramble of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  // ---------------- memory model ----------------
  bit          mem_pend = 0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;
  int          lat      = 0;     // 0 -> random 1..4 per request
  bit          inject_stale = 0;

  // ---------------- reference model (transaction level) ----------------
  // exp_pc : address of the next instruction in program order
  // outst  : a memory request is outstanding
  // live   : the outstanding request has not been invalidated by a redirect
  // held   : a fetched instruction is parked while decode stalls
  logic [31:0] exp_pc = RESET_PC;
  bit          outst = 0, live = 0, held = 0;
  logic [31:0] m_instr = NOP, m_pc = '0;
  bit          m_valid = 0;
  int          loads = 0;

  // One clock cycle: check edge results, drive inputs, check combinational
  // outputs, then advance the model across the coming edge.
  task automatic cycle(input bit rst, input bit stl, input bit rdr, input logic [31:0] rpc);
    bit resp;
    @(posedge clk); #1;
    chk("instr_d", instr_d, m_instr);
    chk("pc_d", pc_d, m_pc);
    chk("sendNop", 32'(sendNop), 32'(!m_valid));
    chk("opcode", 32'(opcode), {25'd0, m_instr[6:0]});
    chk("funct3", 32'(funct3), {29'd0, m_instr[14:12]});
    chk("funct7", 32'(funct7), {25'd0, m_instr[31:25]});

    reset = rst; stall = stl; redirect = rdr; redirect_pc = rpc;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = $urandom;
    if (rst) begin
      mem_pend = 0;
    end else if (inject_stale) begin
      bus.imem_valid = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      inject_stale   = 0;
    end else if (mem_pend) begin
      if (mem_cnt == 0) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = mem_fn(mem_addr);
        mem_pend = 0;
      end else begin
        mem_cnt--;
      end
    end

    @(negedge clk);
    resp = bus.imem_valid;
    chk("ihit", 32'(ihit), 32'(!rdr && ((resp && live) || held)));
    chk("imem_req", 32'(bus.imem_req), 32'(!rst && !rdr && !outst && !held));
    chk("imem_addr", bus.imem_addr, exp_pc);

    if (rst) begin
      exp_pc = RESET_PC; m_instr = NOP; m_pc = '0; m_valid = 0;
      live = 0; outst = 0; held = 0;
    end else begin
      if (resp) outst = 0;
      if (rdr) begin
        m_instr = NOP; m_valid = 0; live = 0; held = 0; exp_pc = rpc;
      end else if (stl) begin
        if (resp && live) begin held = 1; live = 0; end
      end else if (held || (resp && live)) begin
        m_instr = mem_fn(exp_pc); m_pc = exp_pc; m_valid = 1;
        exp_pc  = exp_pc + 32'd4;
        held = 0; live = 0; loads++;
      end else begin
        m_instr = NOP; m_valid = 0;
      end
      if (bus.imem_req) begin
        outst = 1; live = 1;
        mem_pend = 1; mem_addr = bus.imem_addr;
        mem_cnt  = (lat == 0) ? int'($urandom_range(0, 3)) : lat - 1;
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ihit;
    logic        e_sn;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t        tbl[7];
  logic [31:0] ei;
  int          hits;
  int          stall_left;

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    bus.imem_valid = 1'b0; bus.imem_rdata = '0;

    // Reset, then a one-cycle memory serving two instructions.
    tbl[0] = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h1000, 1'b0, 1'b1, NOP,          32'h0};
    tbl[1] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h1000, 1'b0, 1'b1, NOP,          32'h0};
    tbl[2] = '{1'b0, 1'b1, 32'h0050_0093,  1'b0, 32'h1000, 1'b1, 1'b1, NOP,          32'h0};
    tbl[3] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h1004, 1'b0, 1'b0, 32'h0050_0093, 32'h1000};
    tbl[4] = '{1'b0, 1'b1, 32'h0010_8113,  1'b0, 32'h1004, 1'b1, 1'b1, NOP,          32'h1000};
    tbl[5] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h1008, 1'b0, 1'b0, 32'h0010_8113, 32'h1004};
    tbl[6] = '{1'b0, 1'b0, 32'h0,          1'b0, 32'h1008, 1'b0, 1'b1, NOP,          32'h1004};

    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      reset = tbl[i].rst;
      bus.imem_valid = tbl[i].vld;
      bus.imem_rdata = tbl[i].rdata;
      @(negedge clk);
      ei = tbl[i].e_instr;
      chk($sformatf("t%0d_req", i), 32'(bus.imem_req), 32'(tbl[i].e_req));
      chk($sformatf("t%0d_addr", i), bus.imem_addr, tbl[i].e_addr);
      chk($sformatf("t%0d_ihit", i), 32'(ihit), 32'(tbl[i].e_ihit));
      chk($sformatf("t%0d_sendNop", i), 32'(sendNop), 32'(tbl[i].e_sn));
      chk($sformatf("t%0d_instr", i), instr_d, ei);
      chk($sformatf("t%0d_pc", i), pc_d, tbl[i].e_pc);
      chk($sformatf("t%0d_opcode", i), 32'(opcode), {25'd0, ei[6:0]});
      chk($sformatf("t%0d_f3f7", i), {22'd0, funct7, funct3}, {22'd0, ei[31:25], ei[14:12]});
    end

    // Hand over to the model: start from a clean reset.
    @(posedge clk); #1;
    reset = 1'b1; bus.imem_valid = 1'b0;
    @(negedge clk);
    exp_pc = RESET_PC; m_instr = NOP; m_pc = '0; m_valid = 0;
    outst = 0; live = 0; held = 0; mem_pend = 0;

    // ---------------- randomized run ----------------
    lat = 0;
    stall_left = 0;
    for (int n = 0; n < 3000; n++) begin
      bit          r, rd, st;
      logic [31:0] rpc;
      r  = ($urandom_range(0, 199) == 0);
      rd = !r && ($urandom_range(0, 15) == 0);
      if (stall_left > 0) begin
        st = 1; stall_left--;
      end else if ($urandom_range(0, 7) == 0) begin
        st = 1; stall_left = $urandom_range(0, 3);
      end else begin
        st = 0;
      end
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      cycle(r, st, rd, rpc);
    end
    chk("random_progress", 32'(loads >= 100), 32'd1);

    // ---------------- 4-cycle latency: one ihit per 5 cycles ----------------
    lat = 4;
    cycle(1, 0, 0, 0);
    hits = 0;
    for (int n = 0; n < 20; n++) begin
      cycle(0, 0, 0, 0);
      if (ihit) hits++;
    end
    chk("lat4_ihit_count", hits, 4);

    // ---------------- stall across the response -> HOLD ----------------
    lat = 1;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);                    // request 0x1000
    cycle(0, 1, 0, 0);                    // response lands under stall
    cycle(0, 1, 0, 0);
    chk("hold_state", 32'(dbg_state), 32'd2);
    chk("hold_ifid_bubble", 32'(sendNop), 32'd1);
    cycle(0, 1, 0, 0);
    chk("hold_state2", 32'(dbg_state), 32'd2);
    cycle(0, 0, 0, 0);                    // stall released
    cycle(0, 0, 0, 0);
    chk("hold_release_pc", pc_d, 32'h1000);
    chk("hold_release_instr", instr_d, mem_fn(32'h1000));
    chk("hold_next_req", {31'd0, bus.imem_req}, 32'd1);
    chk("hold_next_addr", bus.imem_addr, 32'h1004);

    // ---------------- redirect during WAIT, response 2 cycles later ----------------
    lat = 3;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);                    // request 0x1000
    cycle(0, 0, 1, 32'h2000);             // redirect while waiting
    cycle(0, 0, 0, 0);
    chk("redir_flush_nop", instr_d, NOP);
    chk("redir_flush_sendNop", 32'(sendNop), 32'd1);
    cycle(0, 0, 0, 0);                    // stale response arrives, dropped
    chk("redir_drop_ihit", 32'(ihit), 32'd0);
    cycle(0, 0, 0, 0);
    chk("redir_req", 32'(bus.imem_req), 32'd1);
    chk("redir_addr", bus.imem_addr, 32'h2000);
    for (int n = 0; n < 6; n++) cycle(0, 0, 0, 0);

    // ---------------- redirect + stall while in HOLD ----------------
    lat = 1;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);                    // into HOLD
    cycle(0, 1, 1, 32'h3000);
    chk("holdredir_ihit", 32'(ihit), 32'd0);
    cycle(0, 1, 0, 0);
    chk("holdredir_state", 32'(dbg_state), 32'd0);
    chk("holdredir_req", 32'(bus.imem_req), 32'd1);
    chk("holdredir_addr", bus.imem_addr, 32'h3000);
    chk("holdredir_flush", 32'(sendNop), 32'd1);
    for (int n = 0; n < 4; n++) cycle(0, 0, 0, 0);

    // ---------------- PC wrap at 0xFFFF_FFFC ----------------
    lat = 1;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 32'hFFFF_FFFC);        // redirect in REQ: no request
    cycle(0, 0, 0, 0);
    chk("wrap_req_addr", bus.imem_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0);                    // response
    cycle(0, 0, 0, 0);
    chk("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
    chk("wrap_next_addr", bus.imem_addr, 32'h0000_0000);
    chk("wrap_next_req", 32'(bus.imem_req), 32'd1);

    // ---------------- reset mid-WAIT with a stale response ----------------
    lat = 4;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);                    // request 0x1000
    cycle(0, 0, 0, 0);                    // waiting
    cycle(1, 0, 0, 0);                    // reset mid-WAIT
    inject_stale = 1;
    cycle(0, 0, 0, 0);                    // stale strobe in REQ
    chk("rst_wait_state", 32'(dbg_state), 32'd0);
    chk("rst_wait_ihit", 32'(ihit), 32'd0);
    chk("rst_wait_addr", bus.imem_addr, RESET_PC);
    chk("rst_wait_opcode", 32'(opcode), 32'h13);
    chk("rst_wait_f3f7", {22'd0, funct7, funct3}, 32'd0);
    cycle(0, 0, 0, 0);
    chk("rst_stale_ignored", instr_d, NOP);
    for (int n = 0; n < 6; n++) cycle(0, 0, 0, 0);
    chk("rst_refetch_pc", pc_d, RESET_PC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
